// File: rtl/seq_pattern_gen_if.sv
// Control and serial-output bundle for seq_pattern_gen.
//   start, abort        : transfer request / synchronous abort
//   use_ext, pattern_in : pattern select and external pattern (sampled with start)
//   reps, gap           : repetition count and idle gap length (sampled with start)
//   out, valid          : serial data bit and its qualifier
//   busy, done          : transfer in progress / one-cycle completion pulse
interface seq_pattern_gen_if #(
   parameter int PAT_W = 3,
   parameter int CNT_W = 4,
   parameter int GAP_W = 4
);
   logic             start;
   logic             abort;
   logic             use_ext;
   logic [PAT_W-1:0] pattern_in;
   logic [CNT_W-1:0] reps;
   logic [GAP_W-1:0] gap;
   logic             out;
   logic             valid;
   logic             busy;
   logic             done;

   modport master (
      output start, abort, use_ext, pattern_in, reps, gap,
      input  out, valid, busy, done
   );

   modport slave (
      input  start, abort, use_ext, pattern_in, reps, gap,
      output out, valid, busy, done
   );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter. Shifts a PAT_W-bit pattern MSB-first onto
// bus.out, repeated bus.reps times with bus.gap idle cycles between
// repetitions, under a start/busy/done handshake with synchronous abort.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_pattern_gen_if.slave (control inputs, registered outputs)
module seq_pattern_gen #(
   parameter int               PAT_W   = 3,
   parameter logic [PAT_W-1:0] PATTERN = 3'b101,
   parameter int               CNT_W   = 4,
   parameter int               GAP_W   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   seq_pattern_gen_if.slave   bus
);

   localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(PAT_W - 1);

   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

   state_t           state, state_n;
   logic [PAT_W-1:0] sh, sh_n;
   logic [PAT_W-1:0] pat_lat, pat_lat_n;
   logic [BW-1:0]    bit_cnt, bit_cnt_n;
   logic [CNT_W-1:0] rep_cnt, rep_cnt_n;
   logic [GAP_W-1:0] gap_lat, gap_lat_n;
   logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
   logic             out_q, valid_q, busy_q, done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         sh      <= '0;
         pat_lat <= '0;
         bit_cnt <= '0;
         rep_cnt <= '0;
         gap_lat <= '0;
         gap_cnt <= '0;
         out_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_n;
         sh      <= sh_n;
         pat_lat <= pat_lat_n;
         bit_cnt <= bit_cnt_n;
         rep_cnt <= rep_cnt_n;
         gap_lat <= gap_lat_n;
         gap_cnt <= gap_cnt_n;
         // Outputs are registered from the next state so they line up with
         // the state they describe; the line idles low outside SEND.
         out_q   <= (state_n == SEND) ? sh_n[PAT_W-1] : 1'b0;
         valid_q <= (state_n == SEND);
         busy_q  <= (state_n != IDLE);
         done_q  <= (state_n == DONE);
      end
   end

   always_comb begin
      state_n   = state;
      sh_n      = sh;
      pat_lat_n = pat_lat;
      bit_cnt_n = bit_cnt;
      rep_cnt_n = rep_cnt;
      gap_lat_n = gap_lat;
      gap_cnt_n = gap_cnt;

      case (state)
         IDLE: begin
            // abort has priority over start even in IDLE
            if (bus.start && !bus.abort) begin
               pat_lat_n = bus.use_ext ? bus.pattern_in : PATTERN;
               rep_cnt_n = bus.reps;
               gap_lat_n = bus.gap;
               gap_cnt_n = '0;
               bit_cnt_n = '0;
               sh_n      = bus.use_ext ? bus.pattern_in : PATTERN;
               state_n   = (bus.reps != '0) ? SEND : DONE;
            end
         end

         SEND: begin
            if (bus.abort) begin
               state_n = IDLE;
            end else if (bit_cnt == LAST_BIT) begin
               rep_cnt_n = rep_cnt - 1'b1;
               bit_cnt_n = '0;
               if (rep_cnt == CNT_W'(1)) begin
                  state_n = DONE;
               end else if (gap_lat == '0) begin
                  // back-to-back repetition: reload without a bubble
                  sh_n = pat_lat;
               end else begin
                  gap_cnt_n = gap_lat;
                  state_n   = GAP;
               end
            end else begin
               sh_n      = sh << 1;
               bit_cnt_n = bit_cnt + 1'b1;
            end
         end

         GAP: begin
            if (bus.abort) begin
               state_n = IDLE;
            end else if (gap_cnt == GAP_W'(1)) begin
               sh_n      = pat_lat;
               bit_cnt_n = '0;
               gap_cnt_n = '0;
               state_n   = SEND;
            end else begin
               gap_cnt_n = gap_cnt - 1'b1;
            end
         end

         DONE: begin
            state_n = IDLE;
         end

         default: state_n = IDLE;
      endcase
   end

   assign bus.out   = out_q;
   assign bus.valid = valid_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule
